is_tx_sched: RTL and testbench

//  Scheduler that shares the single UART transmitter between two requesters: the echo path
//  (one byte per received char) and the message streamer (ROM strings such as result/error

---
 rtl/is_tx_sched.sv | 165 ++++++++++++++++
 tb/tb_is_tx_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/is_tx_sched.sv
// Shares one UART transmitter between the echo path and the ROM message streamer.
// Messages are atomic; echo wins arbitration in IDLE and otherwise waits in a one-entry buffer.
module is_tx_sched #(
  parameter int DATA_W    = 8,
  parameter int MEM_WIDTH = 6,
  parameter int ROM_LAT   = 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 echo_req_i,
  input  logic [DATA_W-1:0]    echo_data_i,
  output logic                 echo_drop_o,
  input  logic                 msg_req_i,
  input  logic [MEM_WIDTH-1:0] msg_start_i,
  input  logic [MEM_WIDTH-1:0] msg_end_i,
  output logic                 msg_ack_o,
  output logic                 msg_done_o,
  output logic [MEM_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_W-1:0]    rom_data_i,
  input  logic                 tx_rdy_r_i,
  output logic                 tx_rdy_t_o,
  output logic [DATA_W-1:0]    tx_data_t_o,
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ECHO_TX,
    S_MSG_RD,
    S_MSG_TX,
    S_TX_WAIT
  } state_t;

  localparam logic [1:0] LAT_LAST = 2'(ROM_LAT - 1);

  state_t                 state_q, state_d;
  logic                   ret_msg_q, ret_msg_d;
  logic                   echo_vld_q, echo_vld_d;
  logic [DATA_W-1:0]      echo_buf_q, echo_buf_d;
  logic [MEM_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [MEM_WIDTH-1:0]   end_addr_q, end_addr_d;
  logic [1:0]             lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0]      tx_data_q, tx_data_d;

  logic                   strobe;
  logic                   drain;
  logic                   ack;
  logic                   done;
  logic                   drop;
  logic [DATA_W-1:0]      tx_byte;

  always_comb begin
    state_d    = state_q;
    ret_msg_d  = ret_msg_q;
    echo_vld_d = echo_vld_q;
    echo_buf_d = echo_buf_q;
    cur_addr_d = cur_addr_q;
    end_addr_d = end_addr_q;
    lat_cnt_d  = lat_cnt_q;
    tx_data_d  = tx_data_q;
    strobe     = 1'b0;
    drain      = 1'b0;
    ack        = 1'b0;
    done       = 1'b0;
    drop       = 1'b0;
    tx_byte    = tx_data_q;

    case (state_q)
      S_IDLE: begin
        // An echo byte arriving this cycle also blocks the message, so echo keeps priority.
        if (echo_vld_q) begin
          state_d = S_ECHO_TX;
        end else if (msg_req_i && !echo_req_i && !rstn_i) begin
          ack        = 1'b1;
          cur_addr_d = msg_start_i;
          end_addr_d = msg_end_i;
          lat_cnt_d  = 2'd0;
          state_d    = S_MSG_RD;
        end
      end
      S_ECHO_TX: begin
        if (tx_rdy_r_i) begin
          strobe    = 1'b1;
          drain     = 1'b1;
          tx_byte   = echo_buf_q;
          ret_msg_d = 1'b0;
          state_d   = S_TX_WAIT;
        end
      end
      S_MSG_RD: begin
        if (lat_cnt_q == LAT_LAST) begin
          lat_cnt_d = 2'd0;
          state_d   = S_MSG_TX;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      S_MSG_TX: begin
        // rom_addr_o is held at cur_addr, so rom_data_i stays valid until the strobe.
        if (tx_rdy_r_i) begin
          strobe  = 1'b1;
          tx_byte = rom_data_i;
          state_d = S_TX_WAIT;
          if (cur_addr_q == end_addr_q) begin
            done      = 1'b1;
            ret_msg_d = 1'b0;
          end else begin
            cur_addr_d = cur_addr_q + MEM_WIDTH'(1);
            ret_msg_d  = 1'b1;
          end
        end
      end
      S_TX_WAIT: begin
        if (tx_rdy_r_i) begin
          lat_cnt_d = 2'd0;
          state_d   = ret_msg_q ? S_MSG_RD : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (echo_req_i && (!echo_vld_q || drain)) begin
      echo_vld_d = 1'b1;
      echo_buf_d = echo_data_i;
    end else if (drain) begin
      echo_vld_d = 1'b0;
    end
    drop = echo_req_i && echo_vld_q && !drain;

    if (strobe) begin
      tx_data_d = tx_byte;
    end
  end

  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      state_q    <= S_IDLE;
      ret_msg_q  <= 1'b0;
      echo_vld_q <= 1'b0;
      echo_buf_q <= '0;
      cur_addr_q <= '0;
      end_addr_q <= '0;
      lat_cnt_q  <= 2'd0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ret_msg_q  <= ret_msg_d;
      echo_vld_q <= echo_vld_d;
      echo_buf_q <= echo_buf_d;
      cur_addr_q <= cur_addr_d;
      end_addr_q <= end_addr_d;
      lat_cnt_q  <= lat_cnt_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign echo_drop_o = drop;
  assign msg_ack_o   = ack;
  assign msg_done_o  = done;
  assign rom_addr_o  = cur_addr_q;
  assign tx_rdy_t_o  = strobe;
  assign tx_data_t_o = tx_byte;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_is_tx_sched.sv
// Bench for is_tx_sched: ROM and UART TX models, an expected-byte-stream model and
// directed scenarios for echo, messages, wrap, contention, drain+load and reset.
module tb_is_tx_sched;
  localparam int DW = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          echo_req;
  logic [DW-1:0] echo_data;
  logic          echo_drop;
  logic          msg_req;
  logic [AW-1:0] msg_start;
  logic [AW-1:0] msg_end;
  logic          msg_ack;
  logic          msg_done;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          tx_rdy;
  logic          tx_stb;
  logic [DW-1:0] tx_data;
  logic          busy;

  always #5 clk = ~clk;

  is_tx_sched #(.DATA_W(DW), .MEM_WIDTH(AW), .ROM_LAT(1)) dut (
    .clk_i(clk), .rstn_i(rst),
    .echo_req_i(echo_req), .echo_data_i(echo_data), .echo_drop_o(echo_drop),
    .msg_req_i(msg_req), .msg_start_i(msg_start), .msg_end_i(msg_end),
    .msg_ack_o(msg_ack), .msg_done_o(msg_done),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .tx_rdy_r_i(tx_rdy), .tx_rdy_t_o(tx_stb), .tx_data_t_o(tx_data),
    .busy_o(busy)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          done;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] rom [64];
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_strobe = 0;
  int            n_ack = 0;
  int            n_drop = 0;
  int            hold = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected stream of one message: ROM bytes from s to e inclusive, wrapping at the top.
  task automatic push_msg(input int s, input int e);
    int a;
    a = s;
    for (int k = 0; k < 64; k++) begin
      exp_q.push_back('{d: rom[a], done: (a == e)});
      if (a == e) break;
      a = (a + 1) % 64;
    end
  endtask

  task automatic push_echo(input logic [DW-1:0] b);
    exp_q.push_back('{d: b, done: 1'b0});
  endtask

  task automatic wait_ack();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (msg_ack) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("ack_wait", 32'(got), 32'd1);
    step();
    msg_req = 1'b0;
  endtask

  task automatic req_msg(input int s, input int e);
    msg_start = AW'(s);
    msg_end   = AW'(e);
    msg_req   = 1'b1;
    wait_ack();
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_wait", 32'(ok), 32'd1);
    step();
  endtask

  // Monitor: checks every strobe against the expected stream, then plays ROM and TX.
  initial begin
    logic          nrdy;
    logic [DW-1:0] nrom;
    int            cnt;
    exp_t          e;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (tx_stb) begin
        n_strobe++;
        chk("strobe_when_ready", 32'(tx_rdy), 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_strobe: got byte 0x%0h, expected none", tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", 32'(tx_data), 32'(e.d));
          chk("msg_done_with_byte", 32'(msg_done), 32'(e.done));
        end
      end else if (msg_done) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_without_strobe: got 1, expected 0");
      end
      if (msg_ack) n_ack++;
      if (echo_drop) n_drop++;
      nrom = rom[rom_addr];
      nrdy = tx_rdy;
      if (tx_stb) begin
        nrdy = 1'b0;
        cnt  = hold;
      end else if (!tx_rdy) begin
        if (cnt <= 1) nrdy = 1'b1;
        else cnt--;
      end
      @(posedge clk);
      #1;
      tx_rdy   = nrdy;
      rom_data = nrom;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int s0;
    for (int i = 0; i < 64; i++) rom[i] = 8'(8'h60 + i);
    rom[5] = 8'h45; rom[6] = 8'h52; rom[7] = 8'h52; rom[8] = 8'h0D;
    rom[62] = 8'hC1; rom[63] = 8'hC2; rom[0] = 8'hC3; rom[1] = 8'hC4;

    rst = 1'b1; echo_req = 1'b0; echo_data = '0;
    msg_req = 1'b1; msg_start = 6'd5; msg_end = 6'd8;
    tx_rdy = 1'b1; rom_data = '0;

    // Reset state, with a message request held against it
    repeat (3) step();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobe", 32'(tx_stb), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_ack", 32'(msg_ack), 32'd0);
    chk("rst_done", 32'(msg_done), 32'd0);
    chk("rst_drop", 32'(echo_drop), 32'd0);
    step();
    msg_req = 1'b0;
    rst = 1'b0;
    step();

    // Echo 0x41: strobe two cycles after the request
    push_echo(8'h41);
    echo_req = 1'b1; echo_data = 8'h41;
    @(negedge clk);
    chk("echo_t0_drop", 32'(echo_drop), 32'd0);
    chk("echo_t0_busy", 32'(busy), 32'd0);
    step();
    echo_req = 1'b0;
    @(negedge clk);
    chk("echo_t1_strobe", 32'(tx_stb), 32'd0);
    step();
    @(negedge clk);
    chk("echo_t2_strobe", 32'(tx_stb), 32'd1);
    chk("echo_t2_data", 32'(tx_data), 32'h41);
    chk("echo_t2_busy", 32'(busy), 32'd1);
    step();
    @(negedge clk);
    chk("echo_t3_data_held", 32'(tx_data), 32'h41);
    step();
    wait_idle();

    // Message 5..8 "ERR\r", slow TX
    hold = 10;
    push_msg(5, 8);
    chk("model_len_err", 32'(exp_q.size()), 32'd4);
    chk("model_err_first", 32'(exp_q[0].d), 32'h45);
    chk("model_err_last", 32'(exp_q[3].d), 32'h0D);
    a0 = n_ack;
    msg_start = 6'd5; msg_end = 6'd8; msg_req = 1'b1;
    @(negedge clk);
    chk("msg_ack_t0", 32'(msg_ack), 32'd1);
    step();
    msg_req = 1'b0;
    @(negedge clk);
    chk("msg_rom_addr_t1", 32'(rom_addr), 32'd5);
    chk("msg_ack_t1", 32'(msg_ack), 32'd0);
    step();
    @(negedge clk);
    chk("msg_strobe_t2", 32'(tx_stb), 32'd1);
    chk("msg_data_t2", 32'(tx_data), 32'h45);
    step();
    wait_idle();
    chk("msg_ack_count", 32'(n_ack - a0), 32'd1);

    // Wrap 3E..01 and single-byte 7..7
    hold = 2;
    push_msg(62, 1);
    chk("model_len_wrap", 32'(exp_q.size()), 32'd4);
    chk("model_wrap_third", 32'(exp_q[2].d), 32'hC3);
    req_msg(62, 1);
    wait_idle();
    hold = 1;
    push_msg(7, 7);
    chk("model_len_single", 32'(exp_q.size()), 32'd1);
    chk("model_single_done", 32'(exp_q[0].done), 32'd1);
    req_msg(7, 7);
    wait_idle();

    // Contention: echo and message in the same cycle, then echoes during the message
    hold = 3;
    push_echo(8'h31);
    push_msg(5, 8);
    push_echo(8'h32);
    echo_req = 1'b1; echo_data = 8'h31;
    msg_start = 6'd5; msg_end = 6'd8; msg_req = 1'b1;
    @(negedge clk);
    chk("cont_no_ack", 32'(msg_ack), 32'd0);
    step();
    echo_req = 1'b0;
    wait_ack();
    echo_req = 1'b1; echo_data = 8'h32;
    @(negedge clk);
    chk("cont_echo2_drop", 32'(echo_drop), 32'd0);
    step();
    echo_data = 8'h33;
    @(negedge clk);
    chk("cont_echo3_drop", 32'(echo_drop), 32'd1);
    step();
    echo_req = 1'b0;
    wait_idle();

    // Load in the same cycle the buffer drains
    hold = 1;
    push_echo(8'h51);
    push_echo(8'h52);
    echo_req = 1'b1; echo_data = 8'h51;
    step();
    echo_req = 1'b0;
    step();
    echo_req = 1'b1; echo_data = 8'h52;
    @(negedge clk);
    chk("drain_load_strobe", 32'(tx_stb), 32'd1);
    chk("drain_load_drop", 32'(echo_drop), 32'd0);
    step();
    echo_req = 1'b0;
    wait_idle();

    // Reset after two bytes of a message, then restart
    push_msg(16, 23);
    s0 = n_strobe;
    req_msg(16, 23);
    for (int i = 0; i < 100 && n_strobe < s0 + 2; i++) @(negedge clk);
    chk("mid_two_bytes", 32'(n_strobe - s0), 32'd2);
    step();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_strobe", 32'(tx_stb), 32'd0);
    chk("mid_rst_done", 32'(msg_done), 32'd0);
    chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
    step();
    rst = 1'b0;
    step();
    push_msg(16, 18);
    req_msg(16, 18);
    @(negedge clk);
    chk("restart_rom_addr", 32'(rom_addr), 32'd16);
    step();
    wait_idle();

    chk("drop_count", 32'(n_drop), 32'd1);
    chk("stream_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
